// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer sequencers: FSM states, tag format, ReLU.
package dense_pkg;

    localparam int unsigned DENSE_DATA_W = 16;
    localparam int unsigned DENSE_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } dense_state_e;

    typedef struct packed {
        logic                    valid;
        logic                    first;
        logic                    last;
        logic [DENSE_ADDR_W-1:0] line;
    } dense_tag_t;

    // Width-generic ReLU: x is zero-extended by the caller, w is the real word width.
    function automatic logic [63:0] relu(input logic [63:0] x, input int unsigned w);
        return x[6'(w - 1)] ? '0 : x;
    endfunction

endpackage

// File: rtl/dense_tag_pipe.sv
// Fixed-latency tag shift register tracking issued chunks through the datapath.
module dense_tag_pipe
    import dense_pkg::*;
#(
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  dense_tag_t              tag_i,
    output logic [DENSE_ADDR_W-1:0] bias_line_o,
    output dense_tag_t              out_tag_o
);

    dense_tag_t [PIPE_LAT-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[PIPE_LAT-2:0], tag_i};
        end
    end

    // One stage ahead of the output so the 1-cycle bias ROM lines up.
    assign bias_line_o = stage_q[PIPE_LAT-2].line;
    assign out_tag_o   = stage_q[PIPE_LAT-1];

endmodule

// File: rtl/dense_layer_sequencer.sv
// Issue/accumulate/pack sequencer for one fully-connected layer datapath.
module dense_layer_sequencer
    import dense_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DENSE_DATA_W,
    parameter int unsigned ADDR_WIDTH = DENSE_ADDR_W,
    parameter int unsigned IN_CHUNKS  = 4,
    parameter int unsigned OUT_LINES  = 120,
    parameter int unsigned PIPE_LAT   = 3,
    parameter int unsigned PACK       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       layer_enable,
    input  logic [DATA_WIDTH-1:0]      part_sum,
    input  logic [DATA_WIDTH-1:0]      bias_data,
    output logic [ADDR_WIDTH-1:0]      vec_addr,
    output logic [ADDR_WIDTH-1:0]      param_addr,
    output logic [ADDR_WIDTH-1:0]      bias_addr,
    output logic                       busy,
    output logic                       buf_rd_en,
    output logic                       done,
    output logic                       out_wr_en,
    output logic [ADDR_WIDTH-1:0]      out_addr,
    output logic [PACK*DATA_WIDTH-1:0] out_data
);

    localparam int unsigned OFF_W  = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
    localparam int unsigned LINE_W = (OUT_LINES > 1) ? $clog2(OUT_LINES) : 1;
    localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

    dense_state_e               state_q, state_d;
    logic [OFF_W-1:0]           off_q, off_d;
    logic [LINE_W-1:0]          line_q, line_d;
    logic [DATA_WIDTH-1:0]      acc_q, acc_d;
    logic [PACK*DATA_WIDTH-1:0] pack_q, pack_d;
    logic [PACK*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [ADDR_WIDTH-1:0]      out_addr_q, out_addr_d;
    logic                       wr_q, wr_d;
    logic                       last_wr_q, last_wr_d;

    dense_tag_t                 issue_tag, out_tag;
    logic [DENSE_ADDR_W-1:0]    bias_line;
    logic                       issuing, off_last, last_issue, final_line;
    logic [DATA_WIDTH-1:0]      base, sum, res;

    assign issuing    = (state_q == ST_ISSUE);
    assign off_last   = (off_q == OFF_W'(IN_CHUNKS - 1));
    assign last_issue = issuing && off_last && (line_q == LINE_W'(OUT_LINES - 1));

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        line_d  = line_q;
        unique case (state_q)
            ST_IDLE: begin
                if (layer_enable) begin
                    state_d = ST_ISSUE;
                    off_d   = '0;
                    line_d  = '0;
                end
            end
            ST_ISSUE: begin
                if (off_last) begin
                    off_d  = '0;
                    line_d = line_q + LINE_W'(1);
                end else begin
                    off_d = off_q + OFF_W'(1);
                end
                if (last_issue) begin
                    state_d = ST_DRAIN;
                    line_d  = '0;
                end
            end
            ST_DRAIN: if (last_wr_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = issuing;
        issue_tag.first = issuing && (off_q == '0);
        issue_tag.last  = issuing && off_last;
        issue_tag.line  = issuing ? DENSE_ADDR_W'(line_q) : '0;
    end

    dense_tag_pipe #(
        .PIPE_LAT(PIPE_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .tag_i      (issue_tag),
        .bias_line_o(bias_line),
        .out_tag_o  (out_tag)
    );

    assign vec_addr   = issuing ? ADDR_WIDTH'(off_q) : '0;
    assign param_addr = issuing ? ADDR_WIDTH'(line_q) * ADDR_WIDTH'(IN_CHUNKS) + ADDR_WIDTH'(off_q) : '0;
    assign bias_addr  = ADDR_WIDTH'(bias_line);

    always_comb begin
        acc_d      = acc_q;
        pack_d     = pack_q;
        lane_d     = lane_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        wr_d       = 1'b0;
        last_wr_d  = 1'b0;
        base       = out_tag.first ? '0 : acc_q;
        sum        = base + part_sum + bias_data;
        res        = DATA_WIDTH'(relu(64'(sum), DATA_WIDTH));
        final_line = (out_tag.line == DENSE_ADDR_W'(OUT_LINES - 1));

        if (wr_q) out_addr_d = out_addr_q + ADDR_WIDTH'(1);
        if (state_q == ST_IDLE) begin
            lane_d     = '0;
            pack_d     = '0;
            out_addr_d = '0;
        end

        if (out_tag.valid) begin
            acc_d = base + part_sum;
            if (out_tag.last) begin
                for (int unsigned l = 0; l < PACK; l++) begin
                    if (lane_q == LANE_W'(l)) pack_d[l*DATA_WIDTH +: DATA_WIDTH] = res;
                end
                // The final line flushes a partially filled word; cleared lanes stay 0.
                if (lane_q == LANE_W'(PACK - 1) || final_line) begin
                    wr_d       = 1'b1;
                    last_wr_d  = final_line;
                    out_data_d = pack_d;
                    pack_d     = '0;
                    lane_d     = '0;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            line_q     <= '0;
            acc_q      <= '0;
            pack_q     <= '0;
            lane_q     <= '0;
            out_data_q <= '0;
            out_addr_q <= '0;
            wr_q       <= 1'b0;
            last_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            line_q     <= line_d;
            acc_q      <= acc_d;
            pack_q     <= pack_d;
            lane_q     <= lane_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            wr_q       <= wr_d;
            last_wr_q  <= last_wr_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign buf_rd_en = (state_q == ST_DONE);
    assign out_wr_en = wr_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Scoreboard bench: default layer plus a short odd-length layer with single-chunk lines.
module tb_dense_layer_sequencer;

    logic clk = 1'b0;
    int unsigned vec_cnt = 0;
    int unsigned miscmp  = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    initial forever #5 clk = ~clk;

    task automatic check(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int unsigned OL = (g == 0) ? 120 : 5;
        localparam int unsigned IC = (g == 0) ? 4 : 1;
        localparam int unsigned PL = (g == 0) ? 3 : 2;
        localparam int unsigned PK = 2;
        localparam int unsigned N  = OL * IC;
        localparam int unsigned T  = N + PL + 2;
        localparam int unsigned A  = (N > 400) ? 200 : N / 2 + 1;

        logic        rst_n, layer_enable;
        logic [15:0] part_sum, bias_data;
        logic [15:0] vec_addr, param_addr, bias_addr, out_addr;
        logic        busy, buf_rd_en, done, out_wr_en;
        logic [31:0] out_data;

        logic [15:0] ps   [N];
        logic [15:0] brom [OL];
        wr_t         expq [$];
        bit          fin = 1'b0;

        dense_layer_sequencer #(
            .DATA_WIDTH(16),
            .ADDR_WIDTH(16),
            .IN_CHUNKS (IC),
            .OUT_LINES (OL),
            .PIPE_LAT  (PL),
            .PACK      (PK)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .layer_enable(layer_enable),
            .part_sum    (part_sum),
            .bias_data   (bias_data),
            .vec_addr    (vec_addr),
            .param_addr  (param_addr),
            .bias_addr   (bias_addr),
            .busy        (busy),
            .buf_rd_en   (buf_rd_en),
            .done        (done),
            .out_wr_en   (out_wr_en),
            .out_addr    (out_addr),
            .out_data    (out_data)
        );

        // Bias ROM: one-cycle read latency from bias_addr.
        initial begin
            logic [15:0] prev;
            prev      = '0;
            bias_data = '0;
            forever begin
                @(negedge clk);
                bias_data = (int'(prev) < OL) ? brom[prev] : 16'h0;
                prev      = bias_addr;
            end
        end

        // Monitor: every write strobe is matched against the scoreboard queue.
        initial begin
            wr_t e;
            forever begin
                @(negedge clk);
                if (out_wr_en === 1'b1) begin
                    if (expq.size() == 0) begin
                        check(g, "unexpected_wr", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        check(g, "wr_addr", out_addr, e.addr);
                        check(g, "wr_data", out_data, e.data);
                    end
                end
            end
        end

        task automatic fill(input int unsigned md);
            for (int unsigned l = 0; l < OL; l++) begin
                case (md)
                    2:       brom[l] = 16'(l);
                    4:       brom[l] = 16'h0001;
                    5, 7, 8: brom[l] = 16'($urandom);
                    6:       brom[l] = 16'($urandom_range(0, 16'h0FFF));
                    default: brom[l] = 16'h0000;
                endcase
            end
            for (int unsigned k = 0; k < N; k++) begin
                case (md)
                    0:       ps[k] = 16'h0001;
                    1:       ps[k] = 16'hFFFF;
                    2:       ps[k] = 16'h0000;
                    3:       ps[k] = 16'h2000;
                    4:       ps[k] = 16'h1000;
                    6, 8:    ps[k] = 16'($urandom_range(0, 16'h0FFF));
                    default: ps[k] = 16'($urandom);
                endcase
            end
        endtask

        // Reference: per line, wrap-around sum of its chunks plus bias, ReLU, pack PK per word.
        task automatic build_exp(input int unsigned limit);
            logic [31:0] d;
            logic [15:0] s;
            int unsigned lmax, ln;
            for (int unsigned j = 0; j < (OL + PK - 1) / PK; j++) begin
                d    = '0;
                lmax = 0;
                for (int unsigned l = 0; l < PK; l++) begin
                    ln = j * PK + l;
                    if (ln < OL) begin
                        s = brom[ln];
                        for (int unsigned o = 0; o < IC; o++) s = s + ps[ln * IC + o];
                        d[l*16 +: 16] = s[15] ? 16'h0000 : s;
                        lmax = ln;
                    end
                end
                if (lmax * IC + IC - 1 + PL + 2 <= limit) expq.push_back('{addr: 16'(j), data: d});
            end
        endtask

        task automatic chk_zero(input string tag);
            check(g, {tag, "_busy"}, busy, 0);
            check(g, {tag, "_done"}, done, 0);
            check(g, {tag, "_buf_rd_en"}, buf_rd_en, 0);
            check(g, {tag, "_out_wr_en"}, out_wr_en, 0);
            check(g, {tag, "_out_addr"}, out_addr, 0);
            check(g, {tag, "_out_data"}, out_data, 0);
            check(g, {tag, "_param_addr"}, param_addr, 0);
            check(g, {tag, "_vec_addr"}, vec_addr, 0);
            check(g, {tag, "_bias_addr"}, bias_addr, 0);
        endtask

        task automatic run(input int unsigned md, input int unsigned abort_at, input bit hold_en);
            int unsigned last_c;
            fill(md);
            build_exp((abort_at != 0) ? abort_at : T + 10);
            last_c = (abort_at != 0) ? abort_at : T + 3;
            for (int unsigned c = 0; c <= last_c; c++) begin
                @(negedge clk);
                check(g, "busy", busy, (c >= 1 && c <= T));
                check(g, "done", done, (c == T));
                check(g, "buf_rd_en", buf_rd_en, (c == T));
                check(g, "param_addr", param_addr, (c >= 1 && c <= N) ? 64'(c - 1) : 64'd0);
                check(g, "vec_addr", vec_addr, (c >= 1 && c <= N) ? 64'((c - 1) % IC) : 64'd0);
                layer_enable = (c == 0) || (hold_en && c <= T);
                part_sum = (c >= 1 + PL && c - 1 - PL < N) ? ps[c - 1 - PL] : 16'($urandom);
                if (abort_at != 0 && c == abort_at) begin
                    #1 rst_n = 1'b0;
                end
            end
            if (abort_at != 0) begin
                @(negedge clk);
                chk_zero("abort");
                layer_enable = 1'b0;
                rst_n        = 1'b1;
            end
            check(g, "pending_wr", expq.size(), 0);
        endtask

        initial begin
            rst_n        = 1'b0;
            layer_enable = 1'b0;
            part_sum     = '0;
            for (int unsigned l = 0; l < OL; l++) brom[l] = '0;
            repeat (3) @(negedge clk);
            chk_zero("reset");
            rst_n = 1'b1;
            @(negedge clk);
            run(0, 0, 1'b0);
            run(1, 0, 1'b0);
            run(2, 0, 1'b0);
            run(3, 0, 1'b0);
            run(4, 0, 1'b0);
            run(5, 0, 1'b0);
            run(6, 0, 1'b1);
            run(7, A, 1'b0);
            run(8, 0, 1'b0);
            fin = 1'b1;
        end
    end

    initial begin
        int unsigned waited;
        waited = 0;
        while (!(cfg[0].fin && cfg[1].fin) && waited < 60000) begin
            @(posedge clk);
            waited++;
        end
        check(-1, "timeout", (cfg[0].fin && cfg[1].fin), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
